ibex_if_dummy_merge: RTL and testbench

Merges the fetch stream and the dummy-instruction generator's inserts into the single registered instruction slot that feeds the ID stage. The block sits between the prefetch buffer and the ID stage, downstream of the dummy instruction generator. It decides each cycle whether the slot loads a fetched instruction, a dummy instruction, or nothing. It tags dummies so ID/WB can suppress their architectural effects, and caps back-to-back dummy runs.

---
 rtl/ibex_if_dummy_merge_pkg.sv | 16 +
 rtl/ibex_if_dummy_merge.sv | 133 +++++++++++++
 tb/tb_ibex_if_dummy_merge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_if_dummy_merge_pkg.sv
// Shared constants and types for the IF/ID slot merge of fetched and dummy instructions.
// Holds the consecutive-dummy limit default and the slot-update selector encoding.
package ibex_if_dummy_merge_pkg;

  localparam int unsigned MaxConsecDummyDefault = 4;
  localparam int unsigned ConsecCntW            = 4;

  // What the slot does on a given cycle (flush handled separately, it wins over all).
  typedef enum logic [1:0] {
    SlotHold  = 2'd0,
    SlotFetch = 2'd1,
    SlotDummy = 2'd2,
    SlotEmpty = 2'd3
  } slot_sel_e;

endpackage

// File: rtl/ibex_if_dummy_merge.sv
// IF/ID instruction slot that merges the fetch stream with dummy-instruction inserts,
// tags dummies for ID/WB, caps back-to-back dummy runs and counts inserted dummies.
module ibex_if_dummy_merge
  import ibex_if_dummy_merge_pkg::*;
#(
  parameter bit          DummyInstrEn   = 1'b1,
  parameter int unsigned MaxConsecDummy = MaxConsecDummyDefault,
  parameter int unsigned DummyCntW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fetch_valid_i,
  input  logic [31:0]          fetch_rdata_i,
  input  logic [31:0]          fetch_addr_i,
  input  logic                 fetch_err_i,
  output logic                 fetch_ready_o,
  input  logic                 dummy_instr_en_i,
  input  logic                 insert_dummy_instr_i,
  input  logic [31:0]          dummy_instr_data_i,
  output logic                 advance_o,
  input  logic                 id_in_ready_i,
  output logic                 instr_valid_id_o,
  output logic [31:0]          instr_rdata_id_o,
  output logic [31:0]          instr_addr_id_o,
  output logic                 instr_fetch_err_o,
  output logic                 instr_is_dummy_o,
  output logic                 dummy_dropped_o,
  input  logic                 dummy_cnt_clr_i,
  output logic [DummyCntW-1:0] dummy_cnt_o
);

  localparam logic [ConsecCntW-1:0] MaxConsec = ConsecCntW'(MaxConsecDummy);

  logic                  valid_q;
  logic [31:0]           rdata_q;
  logic [31:0]           addr_q;
  logic                  err_q;
  logic                  dummy_q;
  logic [ConsecCntW-1:0] consec_q;
  logic [DummyCntW-1:0]  cnt_q;

  logic      load;
  logic      dummy_req;
  logic      take_dummy;
  logic      take_fetch;
  slot_sel_e slot_sel;

  // Handshakes: the fetch side transfers when fetch_valid_i & fetch_ready_o; the slot
  // transfers to ID when instr_valid_id_o & id_in_ready_i. The slot refills (advance_o)
  // whenever it is empty or being drained, unless a flush kills it that cycle.
  assign load      = (~valid_q | id_in_ready_i) & ~flush_i;
  // A dummy borrows the pending fetch's PC, so insertion waits for a pending fetch.
  assign dummy_req = DummyInstrEn & dummy_instr_en_i & insert_dummy_instr_i & fetch_valid_i;

  assign take_dummy = load & dummy_req & (consec_q < MaxConsec);
  assign take_fetch = load & fetch_valid_i & ~take_dummy;

  always_comb begin
    slot_sel = SlotHold;
    if (load) begin
      if (take_dummy) begin
        slot_sel = SlotDummy;
      end else if (take_fetch) begin
        slot_sel = SlotFetch;
      end else begin
        slot_sel = SlotEmpty;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      dummy_q  <= 1'b0;
      consec_q <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
      dummy_q  <= 1'b0;
      consec_q <= '0;
    end else begin
      case (slot_sel)
        SlotDummy: begin
          valid_q  <= 1'b1;
          rdata_q  <= dummy_instr_data_i;
          addr_q   <= fetch_addr_i;
          err_q    <= 1'b0;
          dummy_q  <= 1'b1;
          consec_q <= consec_q + ConsecCntW'(1);
        end
        SlotFetch: begin
          valid_q  <= 1'b1;
          rdata_q  <= fetch_rdata_i;
          addr_q   <= fetch_addr_i;
          err_q    <= fetch_err_i;
          dummy_q  <= 1'b0;
          consec_q <= '0;
        end
        SlotEmpty: begin
          valid_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Clear beats a same-cycle increment; flush leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (dummy_cnt_clr_i) begin
      cnt_q <= '0;
    end else if (take_dummy && !(&cnt_q)) begin
      cnt_q <= cnt_q + DummyCntW'(1);
    end
  end

  assign fetch_ready_o     = take_fetch;
  assign advance_o         = load;
  assign dummy_dropped_o   = load & dummy_req & (consec_q == MaxConsec);

  assign instr_valid_id_o  = valid_q;
  assign instr_rdata_id_o  = rdata_q;
  assign instr_addr_id_o   = addr_q;
  assign instr_fetch_err_o = err_q;
  assign instr_is_dummy_o  = dummy_q;
  assign dummy_cnt_o       = cnt_q;

endmodule

// File: tb/tb_ibex_if_dummy_merge.sv
// Directed bench for ibex_if_dummy_merge: a rule-level slot model checked every cycle,
// plus literal expectations at the scenario points.
module tb_ibex_if_dummy_merge;

  localparam int MAXC = 4;
  localparam int CNTW = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            fetch_valid_i;
  logic [31:0]     fetch_rdata_i;
  logic [31:0]     fetch_addr_i;
  logic            fetch_err_i;
  logic            fetch_ready_o;
  logic            dummy_instr_en_i;
  logic            insert_dummy_instr_i;
  logic [31:0]     dummy_instr_data_i;
  logic            advance_o;
  logic            id_in_ready_i;
  logic            instr_valid_id_o;
  logic [31:0]     instr_rdata_id_o;
  logic [31:0]     instr_addr_id_o;
  logic            instr_fetch_err_o;
  logic            instr_is_dummy_o;
  logic            dummy_dropped_o;
  logic            dummy_cnt_clr_i;
  logic [CNTW-1:0] dummy_cnt_o;

  int tests = 0;
  int fails = 0;

  ibex_if_dummy_merge #(
    .DummyInstrEn   (1'b1),
    .MaxConsecDummy (MAXC),
    .DummyCntW      (CNTW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .fetch_valid_i        (fetch_valid_i),
    .fetch_rdata_i        (fetch_rdata_i),
    .fetch_addr_i         (fetch_addr_i),
    .fetch_err_i          (fetch_err_i),
    .fetch_ready_o        (fetch_ready_o),
    .dummy_instr_en_i     (dummy_instr_en_i),
    .insert_dummy_instr_i (insert_dummy_instr_i),
    .dummy_instr_data_i   (dummy_instr_data_i),
    .advance_o            (advance_o),
    .id_in_ready_i        (id_in_ready_i),
    .instr_valid_id_o     (instr_valid_id_o),
    .instr_rdata_id_o     (instr_rdata_id_o),
    .instr_addr_id_o      (instr_addr_id_o),
    .instr_fetch_err_o    (instr_fetch_err_o),
    .instr_is_dummy_o     (instr_is_dummy_o),
    .dummy_dropped_o      (dummy_dropped_o),
    .dummy_cnt_clr_i      (dummy_cnt_clr_i),
    .dummy_cnt_o          (dummy_cnt_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot model: what ID sees, how long the current dummy run is, how many dummies so far.
  bit          m_known = 0;
  bit          m_valid;
  logic [31:0] m_rdata;
  logic [31:0] m_addr;
  bit          m_err;
  bit          m_dummy;
  int          m_run;
  int          m_cnt;

  always @(negedge clk) begin
    bit can_take, wants, is_dummy, is_fetch, dropped;
    if (m_known) begin
      chk("valid", {31'd0, instr_valid_id_o}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rdata", instr_rdata_id_o, m_rdata);
        chk("addr", instr_addr_id_o, m_addr);
        chk("err", {31'd0, instr_fetch_err_o}, {31'd0, m_err});
        chk("is_dummy", {31'd0, instr_is_dummy_o}, {31'd0, m_dummy});
      end
      chk("cnt", {28'd0, dummy_cnt_o}, m_cnt);
    end
    can_take = (!m_valid || id_in_ready_i) && !flush_i;
    wants    = dummy_instr_en_i && insert_dummy_instr_i && fetch_valid_i;
    is_dummy = can_take && wants && (m_run < MAXC);
    dropped  = can_take && wants && (m_run >= MAXC);
    is_fetch = can_take && fetch_valid_i && !is_dummy;
    if (m_known) begin
      chk("advance", {31'd0, advance_o}, {31'd0, can_take});
      chk("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, is_fetch});
      chk("dropped", {31'd0, dummy_dropped_o}, {31'd0, dropped});
    end
    if (rst_i) begin
      m_known = 1;
      m_valid = 0; m_rdata = '0; m_addr = '0; m_err = 0; m_dummy = 0;
      m_run = 0; m_cnt = 0;
    end else begin
      if (dummy_cnt_clr_i) m_cnt = 0;
      else if (is_dummy) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (flush_i) begin
        m_valid = 0; m_dummy = 0; m_run = 0;
      end else if (is_dummy) begin
        m_valid = 1; m_rdata = dummy_instr_data_i; m_addr = fetch_addr_i;
        m_err = 0; m_dummy = 1; m_run = m_run + 1;
      end else if (is_fetch) begin
        m_valid = 1; m_rdata = fetch_rdata_i; m_addr = fetch_addr_i;
        m_err = fetch_err_i; m_dummy = 0; m_run = 0;
      end else if (can_take) begin
        m_valid = 0;
      end
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_fetch(input bit v, input logic [31:0] a, input logic [31:0] d);
    fetch_valid_i = v;
    fetch_addr_i  = a;
    fetch_rdata_i = d;
  endtask

  initial begin
    logic [31:0] a;
    rst_i = 1; flush_i = 0; fetch_err_i = 0; dummy_instr_en_i = 1;
    insert_dummy_instr_i = 0; dummy_instr_data_i = 32'h0000_0013;
    id_in_ready_i = 1; dummy_cnt_clr_i = 0;
    set_fetch(0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_valid", {31'd0, instr_valid_id_o}, 32'd0);
    chk("rst_dummy", {31'd0, instr_is_dummy_o}, 32'd0);
    chk("rst_rdata", instr_rdata_id_o, 32'd0);
    chk("rst_cnt", {28'd0, dummy_cnt_o}, 32'd0);
    rst_i = 0;

    // Streaming fetches
    for (int i = 0; i < 3; i++) begin
      set_fetch(1, 32'h100 + 32'(4 * i), 32'h1111_0013 + 32'(i));
      #1 chk("stream_ready", {31'd0, fetch_ready_o}, 32'd1);
      tick();
      chk("stream_addr", instr_addr_id_o, 32'h100 + 32'(4 * i));
      chk("stream_dummy", {31'd0, instr_is_dummy_o}, 32'd0);
    end
    set_fetch(0, 32'h0, 32'h0);
    tick();
    chk("stream_drain", {31'd0, instr_valid_id_o}, 32'd0);

    // Single insert
    set_fetch(1, 32'h200, 32'h2222_0013);
    insert_dummy_instr_i = 1; dummy_instr_data_i = 32'h02A5_0033;
    #1 chk("ins_ready", {31'd0, fetch_ready_o}, 32'd0);
    tick();
    insert_dummy_instr_i = 0;
    chk("ins_rdata", instr_rdata_id_o, 32'h02A5_0033);
    chk("ins_addr", instr_addr_id_o, 32'h200);
    chk("ins_dummy", {31'd0, instr_is_dummy_o}, 32'd1);
    tick();
    chk("ins_follow", instr_rdata_id_o, 32'h2222_0013);
    chk("ins_cnt", {28'd0, dummy_cnt_o}, 32'd1);
    set_fetch(0, 32'h0, 32'h0);
    tick();

    // Consecutive limit
    set_fetch(1, 32'h300, 32'h3333_0013);
    insert_dummy_instr_i = 1; dummy_instr_data_i = 32'h0010_0013;
    for (int i = 0; i < MAXC; i++) begin
      #1 chk("lim_nodrop", {31'd0, dummy_dropped_o}, 32'd0);
      tick();
      chk("lim_dummy", {31'd0, instr_is_dummy_o}, 32'd1);
    end
    #1 chk("lim_drop", {31'd0, dummy_dropped_o}, 32'd1);
    tick();
    chk("lim_fetch", instr_rdata_id_o, 32'h3333_0013);
    set_fetch(1, 32'h304, 32'h4444_0013);
    #1 chk("lim_restart", {31'd0, dummy_dropped_o}, 32'd0);
    tick();
    chk("lim_redummy", {31'd0, instr_is_dummy_o}, 32'd1);
    chk("lim_cnt", {28'd0, dummy_cnt_o}, 32'd6);
    insert_dummy_instr_i = 0;
    tick();
    set_fetch(0, 32'h0, 32'h0);
    tick();

    // ID stall
    set_fetch(1, 32'h400, 32'h5555_0013);
    tick();
    id_in_ready_i = 0; insert_dummy_instr_i = 1;
    set_fetch(1, 32'h404, 32'h6666_0013);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_adv", {31'd0, advance_o}, 32'd0);
      chk("stall_ready", {31'd0, fetch_ready_o}, 32'd0);
      tick();
      chk("stall_hold", instr_addr_id_o, 32'h400);
      chk("stall_cnt", {28'd0, dummy_cnt_o}, 32'd6);
    end
    id_in_ready_i = 1;
    tick();
    chk("stall_dummy", {31'd0, instr_is_dummy_o}, 32'd1);

    // Flush while slot holds a dummy
    flush_i = 1;
    #1 chk("flush_adv", {31'd0, advance_o}, 32'd0);
    tick();
    flush_i = 0; insert_dummy_instr_i = 0;
    chk("flush_valid", {31'd0, instr_valid_id_o}, 32'd0);
    chk("flush_dummy", {31'd0, instr_is_dummy_o}, 32'd0);
    chk("flush_cnt", {28'd0, dummy_cnt_o}, 32'd7);

    // Counter saturation and clear
    set_fetch(0, 32'h0, 32'h0);
    dummy_cnt_clr_i = 1;
    tick();
    dummy_cnt_clr_i = 0;
    chk("clr_cnt", {28'd0, dummy_cnt_o}, 32'd0);
    a = 32'h600;
    insert_dummy_instr_i = 1;
    for (int i = 0; i < 21; i++) begin
      set_fetch(1, a, 32'h7000_0013 + a);
      tick();
      if (i % 5 == 4) a = a + 32'd4;
    end
    chk("sat_cnt", {28'd0, dummy_cnt_o}, 32'hF);
    dummy_cnt_clr_i = 1;
    tick();
    dummy_cnt_clr_i = 0;
    chk("clr_wins", {28'd0, dummy_cnt_o}, 32'd0);

    // CSR enable off: request ignored
    dummy_instr_en_i = 0;
    #1 chk("en_off_ready", {31'd0, fetch_ready_o}, 32'd1);
    tick();
    chk("en_off_dummy", {31'd0, instr_is_dummy_o}, 32'd0);
    dummy_instr_en_i = 1;

    // Reset mid-run overrides flush and insert
    rst_i = 1; flush_i = 1;
    tick();
    rst_i = 0; flush_i = 0; insert_dummy_instr_i = 0;
    chk("rst2_valid", {31'd0, instr_valid_id_o}, 32'd0);
    chk("rst2_cnt", {28'd0, dummy_cnt_o}, 32'd0);

    // Fetch error propagation; dummies never carry it
    fetch_err_i = 1;
    set_fetch(1, 32'h700, 32'h8888_0013);
    tick();
    chk("err_fetch", {31'd0, instr_fetch_err_o}, 32'd1);
    set_fetch(1, 32'h704, 32'h9999_0013);
    insert_dummy_instr_i = 1;
    tick();
    chk("err_dummy", {31'd0, instr_fetch_err_o}, 32'd0);
    insert_dummy_instr_i = 0;
    tick();
    chk("err_after", instr_addr_id_o, 32'h704);
    fetch_err_i = 0;
    set_fetch(0, 32'h0, 32'h0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
